// File: rtl/scsu_dram_arb_pkg.sv
// Shared definitions for the dmem arbiter slice.
//   SCSU_DRAM_DW / SCSU_DRAM_AW : default data / word-address widths of dmem
//   rd_owner_e                  : which requester owns the read data returning next cycle
//   STAT_W                      : width of the optional statistics counters
package scsu_dram_arb_pkg;

  localparam int unsigned SCSU_DRAM_DW = 16;
  localparam int unsigned SCSU_DRAM_AW = 11;
  localparam int unsigned STAT_W       = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/scsu_dram_arb_stats.sv
// Statistics counters for scsu_dram_arb (present only when SCSU_DRAM_ARB_STATS_EN
// is defined; the file compiles to nothing otherwise so no stray top level appears).
//   clk, rst       : clock, asynchronous active-low reset
//   clr            : synchronous clear, wins over a coincident increment
//   host_inc       : count one host grant this cycle
//   stall_inc      : count one core stall this cycle
//   host_grants    : saturating count of host grants
//   core_stalls    : saturating count of core stalls
`ifdef SCSU_DRAM_ARB_STATS_EN
module scsu_dram_arb_stats
  import scsu_dram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              host_inc,
  input  logic              stall_inc,
  output logic [STAT_W-1:0] host_grants,
  output logic [STAT_W-1:0] core_stalls
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      host_grants <= '0;
      core_stalls <= '0;
    end else if (clr) begin
      host_grants <= '0;
      core_stalls <= '0;
    end else begin
      if (host_inc && (host_grants != '1))
        host_grants <= host_grants + 1'b1;
      if (stall_inc && (core_stalls != '1))
        core_stalls <= core_stalls + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/scsu_dram_arb.sv
// Arbiter for the single-port dmem shared by the scs16 core and the host slave bus.
// The core has priority; a host request denied MAX_WAIT consecutive cycles is forced
// through, stalling the core for that one cycle.
//   clk, rst                          : clock, asynchronous active-low reset
//   core_cs/core_we/core_addr/core_wdata : core request (we==00 is a read)
//   core_rdata                        : dmem read data, valid cycle after a core read grant
//   core_stall                        : core request not served this cycle
//   host_req/host_we/host_addr/host_wdata: host request, held until host_ack
//   host_ack                          : host granted this cycle
//   host_rdata/host_rvalid            : host read data, cycle after a granted host read
//   dram_cs/dram_we/dram_addr/dram_wdata : to dmem; dram_rdata from dmem (1-cycle latency)
// Optional feature macro SCSU_DRAM_ARB_STATS_EN adds stat_clr (in), stat_host_grants and
// stat_core_stalls (out) backed by scsu_dram_arb_stats.
module scsu_dram_arb
  import scsu_dram_arb_pkg::*;
#(
  parameter int unsigned DW       = SCSU_DRAM_DW,
  parameter int unsigned AW       = SCSU_DRAM_AW,
  parameter int unsigned MAX_WAIT = 4
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          core_cs,
  input  logic [1:0]    core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic [1:0]    host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          dram_cs,
  output logic [1:0]    dram_we,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_wdata,
  input  logic [DW-1:0] dram_rdata
`ifdef SCSU_DRAM_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_host_grants,
  output logic [STAT_W-1:0] stat_core_stalls
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic      [3:0] wait_cnt;
  rd_owner_e       rd_owner;
  rd_owner_e       rd_owner_nxt;
  logic            force_gnt;
  logic            host_gnt;
  logic            core_gnt;

  always_comb begin
    force_gnt  = host_req & (wait_cnt == WAIT_MAX);
    host_gnt   = host_req & (~core_cs | force_gnt);
    core_gnt   = core_cs & ~host_gnt;
    core_stall = core_cs & host_gnt;
    host_ack   = host_gnt;
  end

  always_comb begin
    dram_cs    = 1'b0;
    dram_we    = '0;
    dram_addr  = '0;
    dram_wdata = '0;
    if (host_gnt) begin
      dram_cs    = 1'b1;
      dram_we    = host_we;
      dram_addr  = host_addr;
      dram_wdata = host_wdata;
    end else if (core_gnt) begin
      dram_cs    = 1'b1;
      dram_we    = core_we;
      dram_addr  = core_addr;
      dram_wdata = core_wdata;
    end
  end

  // Counts consecutive denied host cycles; only a core-blocked pending request advances it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (!host_req || host_gnt) begin
      wait_cnt <= '0;
    end else if (core_cs && (wait_cnt < WAIT_MAX)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (host_gnt && (host_we == 2'b00))
      rd_owner_nxt = OWN_HOST;
    else if (core_gnt && (core_we == 2'b00))
      rd_owner_nxt = OWN_CORE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rd_owner <= OWN_NONE;
    else
      rd_owner <= rd_owner_nxt;
  end

  always_comb begin
    host_rvalid = (rd_owner == OWN_HOST);
    host_rdata  = host_rvalid ? dram_rdata : '0;
    core_rdata  = dram_rdata;
  end

`ifdef SCSU_DRAM_ARB_STATS_EN
  scsu_dram_arb_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .clr         (stat_clr),
    .host_inc    (host_gnt),
    .stall_inc   (core_stall),
    .host_grants (stat_host_grants),
    .core_stalls (stat_core_stalls)
  );
`endif

endmodule

// File: tb/tb_scsu_dram_arb.sv
// Self-checking bench for scsu_dram_arb: directed scenarios with literal expectations plus
// a short pseudo-random phase, all compared every cycle against a request-level model.
module tb_scsu_dram_arb;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_cs = 1'b0;
  logic [1:0]  core_we = '0;
  logic [10:0] core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic [15:0] core_rdata;
  logic        core_stall;
  logic        host_req = 1'b0;
  logic [1:0]  host_we = '0;
  logic [10:0] host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        dram_cs;
  logic [1:0]  dram_we;
  logic [10:0] dram_addr;
  logic [15:0] dram_wdata;
  logic [15:0] dram_rdata = '0;
`ifdef SCSU_DRAM_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_host_grants;
  logic [15:0] stat_core_stalls;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scsu_dram_arb #(.DW(16), .AW(11), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .core_cs(core_cs), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .dram_cs(dram_cs), .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_rdata(dram_rdata)
`ifdef SCSU_DRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_host_grants(stat_host_grants), .stat_core_stalls(stat_core_stalls)
`endif
  );

  // dmem stand-in: registered read of the old word, byte-enabled write at the same edge.
  logic [15:0] mem [2048];
  always @(posedge clk) begin
    if (dram_cs) begin
      dram_rdata <= mem[dram_addr];
      if (dram_we[0]) mem[dram_addr][7:0]  <= dram_wdata[7:0];
      if (dram_we[1]) mem[dram_addr][15:8] <= dram_wdata[15:8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Request-level model: host is served at once if the core is idle, otherwise after
  // MAX_WAIT denied cycles; the expected memory image tracks every served write.
  logic [15:0] ref_mem [2048];
  int          m_denied = 0;
  int          m_pend   = 0;        // 0 nothing, 1 core read, 2 host read
  logic [15:0] m_data   = '0;
  int          m_hgnt   = 0;
  int          m_stall  = 0;

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] we,
                                        input logic [15:0] wd);
    logic [15:0] r;
    r = old;
    if (we[0]) r[7:0]  = wd[7:0];
    if (we[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  function automatic logic host_wins();
    return host_req && (!core_cs || m_denied >= MAX_WAIT);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_denied = 0;
      m_pend   = 0;
      m_hgnt   = 0;
      m_stall  = 0;
    end else begin
      logic hg;
      hg = host_wins();
`ifdef SCSU_DRAM_ARB_STATS_EN
      if (stat_clr) begin
        m_hgnt  = 0;
        m_stall = 0;
      end else begin
        if (hg && m_hgnt < 65535) m_hgnt++;
        if (hg && core_cs && m_stall < 65535) m_stall++;
      end
`endif
      m_pend = 0;
      if (hg) begin
        m_denied = 0;
        if (host_we == 2'b00) begin m_pend = 2; m_data = ref_mem[host_addr]; end
        else ref_mem[host_addr] = merge(ref_mem[host_addr], host_we, host_wdata);
      end else if (core_cs) begin
        m_denied = host_req ? ((m_denied < MAX_WAIT) ? m_denied + 1 : MAX_WAIT) : 0;
        if (core_we == 2'b00) begin m_pend = 1; m_data = ref_mem[core_addr]; end
        else ref_mem[core_addr] = merge(ref_mem[core_addr], core_we, core_wdata);
      end else begin
        m_denied = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic hg, cg;
    logic [1:0]  ewe;
    logic [10:0] eaddr;
    logic [15:0] ewd;
    hg = host_wins();
    cg = core_cs && !hg;
    ewe = hg ? host_we : (cg ? core_we : 2'b00);
    eaddr = hg ? host_addr : (cg ? core_addr : 11'd0);
    ewd = hg ? host_wdata : (cg ? core_wdata : 16'd0);
    chk("host_ack", 32'(host_ack), 32'(hg));
    chk("core_stall", 32'(core_stall), 32'(core_cs && hg));
    chk("dram_cs", 32'(dram_cs), 32'(hg || cg));
    chk("dram_we", 32'(dram_we), 32'(ewe));
    chk("dram_addr", 32'(dram_addr), 32'(eaddr));
    chk("dram_wdata", 32'(dram_wdata), 32'(ewd));
    chk("host_rvalid", 32'(host_rvalid), 32'(m_pend == 2));
    chk("host_rdata", 32'(host_rdata), (m_pend == 2) ? 32'(m_data) : 32'd0);
    if (m_pend == 1) chk("core_rdata", 32'(core_rdata), 32'(m_data));
`ifdef SCSU_DRAM_ARB_STATS_EN
    chk("stat_host_grants", 32'(stat_host_grants), 32'(m_hgnt));
    chk("stat_core_stalls", 32'(stat_core_stalls), 32'(m_stall));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input logic cs, input logic [1:0] we, input logic [10:0] a,
                          input logic [15:0] d);
    core_cs = cs; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_host(input logic rq, input logic [1:0] we, input logic [10:0] a,
                          input logic [15:0] d);
    host_req = rq; host_we = we; host_addr = a; host_wdata = d;
  endtask

  initial begin
    int ack_at, stalls, acks;
    logic a;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
      ref_mem[i] = mem[i];
    end
    mem[11'h010] = 16'hBEEF; ref_mem[11'h010] = 16'hBEEF;
    mem[11'h7FF] = 16'hAB00; ref_mem[11'h7FF] = 16'hAB00;
    mem[11'h020] = 16'h5555; ref_mem[11'h020] = 16'h5555;

    repeat (2) step();
    @(negedge clk);
    chk("reset_rvalid", 32'(host_rvalid), 32'd0);
    chk("reset_dram_cs", 32'(dram_cs), 32'd0);
    step();
    rst = 1'b1;
    step();

    // Host read with idle core
    set_host(1'b1, 2'b00, 11'h010, 16'h0);
    @(negedge clk);
    chk("t1_ack", 32'(host_ack), 32'd1);
    chk("t1_stall", 32'(core_stall), 32'd0);
    step();
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    @(negedge clk);
    chk("t1_rvalid", 32'(host_rvalid), 32'd1);
    chk("t1_rdata", 32'(host_rdata), 32'h0000BEEF);
    step();

    // Core busy every cycle: host forced through after MAX_WAIT denials
    ack_at = -1; stalls = 0;
    set_core(1'b1, 2'b00, 11'h030, 16'h0);
    set_host(1'b1, 2'b11, 11'h040, 16'h0F0F);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      a = host_ack;
      if (a) ack_at = k;
      if (core_stall) stalls++;
      step();
      if (a) host_req = 1'b0;
    end
    chk("t2_ack_cycle", 32'(ack_at), 32'd4);
    chk("t2_stall_count", 32'(stalls), 32'd1);
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    step();

    // Host low-byte write then core read of the top word
    set_host(1'b1, 2'b01, 11'h7FF, 16'h1234);
    step();
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    set_core(1'b1, 2'b00, 11'h7FF, 16'h0);
    step();
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    @(negedge clk);
    chk("t3_core_rdata", 32'(core_rdata), 32'h0000AB34);
    step();

    // Same-address collision: core read wins, sees old data; host write follows
    set_core(1'b1, 2'b00, 11'h020, 16'h0);
    set_host(1'b1, 2'b11, 11'h020, 16'h1111);
    @(negedge clk);
    chk("t4_first_ack", 32'(host_ack), 32'd0);
    step();
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    @(negedge clk);
    chk("t4_second_ack", 32'(host_ack), 32'd1);
    chk("t4_old_data", 32'(core_rdata), 32'h00005555);
    step();
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    set_core(1'b1, 2'b00, 11'h020, 16'h0);
    step();
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    @(negedge clk);
    chk("t4_new_data", 32'(core_rdata), 32'h00001111);
    step();

    // Reset right after a granted host read
    set_host(1'b1, 2'b00, 11'h010, 16'h0);
    step();
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rvalid", 32'(host_rvalid), 32'd0);
    chk("t5_rdata", 32'(host_rdata), 32'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_idle_cs", 32'(dram_cs), 32'd0);
    chk("t5_idle_addr", 32'(dram_addr), 32'd0);
    step();
    // Denials accumulated before a reset must not shorten the wait afterwards
    set_core(1'b1, 2'b00, 11'h005, 16'h0);
    set_host(1'b1, 2'b00, 11'h006, 16'h0);
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    ack_at = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = host_ack;
      if (a && ack_at < 0) ack_at = k;
      step();
      if (a) host_req = 1'b0;
    end
    chk("t5_wait_restart", 32'(ack_at), 32'd4);
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    step();

`ifdef SCSU_DRAM_ARB_STATS_EN
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    acks = 0;
    set_core(1'b1, 2'b00, 11'h001, 16'h0);
    set_host(1'b1, 2'b00, 11'h002, 16'h0);
    for (int k = 0; k < 30 && acks < 3; k++) begin
      @(negedge clk);
      if (host_ack) acks++;
      step();
    end
    host_req = 1'b0;
    @(negedge clk);
    chk("t6_grants", 32'(stat_host_grants), 32'd3);
    chk("t6_stalls", 32'(stat_core_stalls), 32'd3);
    step();
    host_req = 1'b1;
    repeat (4) step();
    stat_clr = 1'b1;
    @(negedge clk);
    chk("t6_forced_ack", 32'(host_ack), 32'd1);
    step();
    stat_clr = 1'b0;
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    @(negedge clk);
    chk("t6_clr_grants", 32'(stat_host_grants), 32'd0);
    chk("t6_clr_stalls", 32'(stat_core_stalls), 32'd0);
    step();
`else
    acks = 0;
`endif

    // Mixed traffic on a small address window to provoke collisions
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a = host_ack;
      step();
      set_core(1'(($urandom % 3) != 0), 2'($urandom), 11'($urandom % 16), 16'($urandom));
      if (a || !host_req)
        set_host(1'($urandom), 2'($urandom), 11'($urandom % 16), 16'($urandom));
    end
    set_core(1'b0, 2'b00, 11'h0, 16'h0);
    set_host(1'b0, 2'b00, 11'h0, 16'h0);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
